uart_tx: RTL

UART transmitter, the transmit-side counterpart of `uart_rx` in the same serial peripheral. It accepts a parallel byte through a single-cycle enable, then serialises it onto `uart_txd` as start bit, 8 data bits LSB-first, and stop bit(s) at a fixed bit rate derived from the system clock. It reports a busy flag so the host can pace writes. It is the loopback partner used to exercise `uart_rx` in system benches.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_bit_timer.sv | 33 +++
 rtl/uart_tx.sv | 102 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line levels and bit-timing helper.
// Imported by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam logic UART_IDLE  = 1'b1;
  localparam logic UART_START = 1'b0;

  function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter; pulses bit_done_o on the last cycle of each bit.
// Held at zero while restart_i is high so the first bit after restart is full length.
module uart_bit_timer #(
  parameter int CYCLES_PER_BIT = 5000
) (
  input  logic clk,
  input  logic reset,
  input  logic restart_i,
  input  logic enable_i,
  output logic bit_done_o
);

  localparam int CW = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_last;

  assign at_last    = (cnt_q == LAST);
  assign bit_done_o = enable_i && !restart_i && at_last;

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i)     cnt_d = '0;
    else if (enable_i) cnt_d = at_last ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, PAYLOAD_BITS data bits LSB first, STOP_BITS stop bits.
// The serial line and busy flag are both registered outputs.
module uart_tx
  import uart_pkg::*;
#(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 48000000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    uart_tx_en,
  input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
  output logic                    uart_tx_busy,
  output logic                    uart_txd
);

  localparam int CPB = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int IW  = $clog2(PAYLOAD_BITS + 1);
  localparam logic [IW-1:0] LAST_DATA = IW'(PAYLOAD_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  uart_state_t             state_q, state_d;
  logic [PAYLOAD_BITS-1:0] sr_q, sr_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    txd_q, txd_d;
  logic                    busy_q, busy_d;
  logic                    bit_done;

  // Timer is parked in IDLE, so counting starts from zero on the acceptance edge.
  uart_bit_timer #(.CYCLES_PER_BIT(CPB)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .restart_i (state_q == IDLE),
    .enable_i  (state_q != IDLE),
    .bit_done_o(bit_done)
  );

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    txd_d   = txd_q;
    case (state_q)
      IDLE: begin
        txd_d = UART_IDLE;
        if (uart_tx_en) begin
          state_d = START;
          sr_d    = uart_tx_data;
          idx_d   = '0;
          txd_d   = UART_START;
        end
      end
      START: if (bit_done) begin
        state_d = DATA;
        txd_d   = sr_q[0];
      end
      DATA: if (bit_done) begin
        if (idx_q == LAST_DATA) begin
          state_d = STOP;
          idx_d   = '0;
          txd_d   = UART_IDLE;
        end else begin
          sr_d  = {1'b0, sr_q[PAYLOAD_BITS-1:1]};
          idx_d = idx_q + 1'b1;
          txd_d = sr_d[0];
        end
      end
      STOP: if (bit_done) begin
        if (idx_q == LAST_STOP) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      idx_q   <= '0;
      txd_q   <= UART_IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
    end
  end

  assign uart_txd     = txd_q;
  assign uart_tx_busy = busy_q;

endmodule
